meas_gate_sched: RTL and testbench



---
 rtl/meas_gate_sched_if.sv | 24 ++
 rtl/meas_gate_sched.sv | 164 ++++++++++++++++
 tb/tb_meas_gate_sched.sv | 269 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/meas_gate_sched_if.sv
// rtl/meas_gate_sched_if.sv - host control/result bundle for the measurement gate sequencer
interface meas_gate_sched_if #(
  parameter int CNT_W = 32
);
  logic             start;
  logic             abort;
  logic [CNT_W-1:0] gate_len;
  logic [CNT_W-1:0] timeout_len;
  logic             busy;
  logic             done;
  logic             timeout;
  logic [CNT_W-1:0] ref_cnt;
  logic [CNT_W-1:0] sig_cnt;

  modport master (
    output start, abort, gate_len, timeout_len,
    input  busy, done, timeout, ref_cnt, sig_cnt
  );

  modport slave (
    input  start, abort, gate_len, timeout_len,
    output busy, done, timeout, ref_cnt, sig_cnt
  );
endinterface

// File: rtl/meas_gate_sched.sv
// rtl/meas_gate_sched.sv - equal-precision gate sequencer: opens/closes fgate on sig_in rising edges
// and counts clk cycles and signal periods over whole signal periods.
module meas_gate_sched #(
  parameter int CNT_W = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  meas_gate_sched_if.slave    host,
  input  logic                sig_in,
  output logic                fgate
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ARM   = 3'd1,
    GATE  = 3'd2,
    CLOSE = 3'd3,
    DONE  = 3'd4
  } state_t;

  localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);
  localparam logic [CNT_W-1:0] ALL_ONES = '1;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == ALL_ONES) ? v : v + ONE;
  endfunction

  state_t           state_q, state_d;
  logic             s1, s2, s3;
  logic             rise_det;
  logic [CNT_W-1:0] ref_acc, ref_d;
  logic [CNT_W-1:0] sig_acc, sig_d;
  logic [CNT_W-1:0] gate_tmr, gate_d;
  logic [CNT_W-1:0] to_tmr, to_d;
  logic [CNT_W-1:0] glen_q, glen_d;
  logic [CNT_W-1:0] tlen_q, tlen_d;
  logic             to_en, to_hit, gate_hit;
  logic             fin_ok, fin_to;

  assign rise_det = s2 & ~s3;
  assign to_en    = (tlen_q != '0);
  assign to_hit   = to_en && (to_tmr == tlen_q - ONE);
  assign gate_hit = (gate_tmr == glen_q - ONE);

  always_comb begin
    state_d = state_q;
    ref_d   = ref_acc;
    sig_d   = sig_acc;
    gate_d  = gate_tmr;
    to_d    = to_tmr;
    glen_d  = glen_q;
    tlen_d  = tlen_q;
    fin_ok  = 1'b0;
    fin_to  = 1'b0;
    case (state_q)
      IDLE: begin
        if (host.start) begin
          glen_d  = (host.gate_len == '0) ? ONE : host.gate_len;
          tlen_d  = host.timeout_len;
          to_d    = '0;
          state_d = ARM;
        end
      end
      ARM: begin
        to_d = to_tmr + ONE;
        if (rise_det) begin
          ref_d   = '0;
          sig_d   = '0;
          gate_d  = '0;
          state_d = GATE;
        end else if (to_hit) begin
          fin_to  = 1'b1;
          state_d = DONE;
        end
      end
      GATE: begin
        ref_d  = sat_inc(ref_acc);
        gate_d = gate_tmr + ONE;
        if (rise_det) sig_d = sat_inc(sig_acc);
        if (gate_hit) begin
          // An edge landing on the expiry cycle is itself the closing edge.
          if (rise_det) begin
            fin_ok  = 1'b1;
            state_d = DONE;
          end else begin
            to_d    = '0;
            state_d = CLOSE;
          end
        end
      end
      CLOSE: begin
        ref_d = sat_inc(ref_acc);
        to_d  = to_tmr + ONE;
        if (rise_det) begin
          sig_d   = sat_inc(sig_acc);
          fin_ok  = 1'b1;
          state_d = DONE;
        end else if (to_hit) begin
          fin_to  = 1'b1;
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (host.abort) begin
      state_d = IDLE;
      fin_ok  = 1'b0;
      fin_to  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      s1       <= 1'b0;
      s2       <= 1'b0;
      s3       <= 1'b0;
      ref_acc  <= '0;
      sig_acc  <= '0;
      gate_tmr <= '0;
      to_tmr   <= '0;
      glen_q   <= '0;
      tlen_q   <= '0;
    end else begin
      state_q  <= state_d;
      s1       <= sig_in;
      s2       <= s1;
      s3       <= s2;
      ref_acc  <= ref_d;
      sig_acc  <= sig_d;
      gate_tmr <= gate_d;
      to_tmr   <= to_d;
      glen_q   <= glen_d;
      tlen_q   <= tlen_d;
    end
  end

  // Outputs are decoded from the next state so they change on the same edge as the state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fgate        <= 1'b0;
      host.busy    <= 1'b0;
      host.done    <= 1'b0;
      host.timeout <= 1'b0;
      host.ref_cnt <= '0;
      host.sig_cnt <= '0;
    end else begin
      fgate     <= (state_d == GATE) || (state_d == CLOSE);
      host.busy <= (state_d != IDLE);
      host.done <= (state_d == DONE);
      if (fin_ok) begin
        host.ref_cnt <= ref_d;
        host.sig_cnt <= sig_d;
        host.timeout <= 1'b0;
      end else if (fin_to) begin
        host.ref_cnt <= '0;
        host.sig_cnt <= '0;
        host.timeout <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_meas_gate_sched.sv
// tb/tb_meas_gate_sched.sv - directed self-checking bench for meas_gate_sched
module tb_meas_gate_sched;

  logic        clk;
  logic        rst_n;
  logic        sig_in;
  logic        fgate;

  meas_gate_sched_if #(.CNT_W(32)) bus ();

  meas_gate_sched #(.CNT_W(32)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .host   (bus),
    .sig_in (sig_in),
    .fgate  (fgate)
  );

  int checks = 0;
  int passed = 0;

  int cyc = 0;
  bit mon_en = 0;
  bit sig_prev = 0;
  int sig_rise_cyc = -1;
  int fg_rise = -1;
  int fg_hi = 0;
  int done_n = 0;

  bit sig_en = 0;
  int per = 10;
  int ph = 0;
  int nedges = 0;
  int stop_n = 0;

  int cyc_arm;
  int cyc_done;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Periodic signal source, updated 3 ns after each rising clk edge.
  initial begin
    sig_in = 1'b0;
    forever begin
      @(posedge clk);
      #3;
      if (!sig_en) begin
        ph     = 0;
        nedges = 0;
        sig_in = 1'b0;
      end else begin
        if (ph == 0) begin
          if (stop_n == 0 || nedges < stop_n) begin
            sig_in = 1'b1;
            nedges++;
          end
        end else if (ph == per / 2) begin
          sig_in = 1'b0;
        end
        ph = (ph == per - 1) ? 0 : ph + 1;
      end
    end
  end

  always @(posedge clk) begin
    cyc++;
    if (mon_en && sig_in && !sig_prev && sig_rise_cyc < 0) sig_rise_cyc = cyc;
    sig_prev = sig_in;
  end

  always @(negedge clk) begin
    if (mon_en) begin
      if (fgate) begin
        fg_hi++;
        if (fg_rise < 0) fg_rise = cyc;
      end
      if (bus.done) done_n++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  task automatic clear_mon();
    mon_en       = 1;
    sig_rise_cyc = -1;
    fg_rise      = -1;
    fg_hi        = 0;
    done_n       = 0;
  endtask

  task automatic wait_done(input int max, input string tag);
    int n;
    n = 0;
    while (bus.done !== 1'b1 && n < max) begin
      tick();
      n++;
    end
    cyc_done = cyc;
    check(tag, bus.done, 1'b1);
  endtask

  task automatic wait_fgate(input int max, input string tag);
    int n;
    n = 0;
    while (fgate !== 1'b1 && n < max) begin
      tick();
      n++;
    end
    check(tag, fgate, 1'b1);
  endtask

  task automatic do_start(input int glen, input int tlen);
    bus.gate_len    = glen;
    bus.timeout_len = tlen;
    bus.start       = 1'b1;
    tick();
    bus.start       = 1'b0;
  endtask

  task automatic quiesce();
    sig_en = 0;
    stop_n = 0;
    repeat (5) tick();
  endtask

  initial begin
    rst_n           = 1'b0;
    bus.start       = 1'b0;
    bus.abort       = 1'b0;
    bus.gate_len    = '0;
    bus.timeout_len = '0;
    repeat (3) tick();
    check("rst_fgate", fgate, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_done", bus.done, 0);
    check("rst_timeout", bus.timeout, 0);
    check("rst_ref", bus.ref_cnt, 0);
    check("rst_sig", bus.sig_cnt, 0);
    rst_n = 1'b1;
    repeat (3) tick();

    // Period 10, gate 25: closes on the 3rd edge after 30 clk
    clear_mon();
    do_start(25, 0);
    check("t1_busy", bus.busy, 1);
    repeat (2) tick();
    per    = 10;
    sig_en = 1;
    wait_done(200, "t1_done_seen");
    check("t1_ref", bus.ref_cnt, 30);
    check("t1_sig", bus.sig_cnt, 3);
    check("t1_timeout", bus.timeout, 0);
    check("t1_fgate_lat", fg_rise, sig_rise_cyc + 2);
    check("t1_fgate_len", fg_hi, 30);
    check("t1_fgate_at_done", fgate, 0);
    check("t1_busy_in_done", bus.busy, 1);
    tick();
    check("t1_done_1cyc", bus.done, 0);
    check("t1_busy_after", bus.busy, 0);
    repeat (3) tick();
    check("t1_done_count", done_n, 1);
    quiesce();

    // No signal, timeout 100 counted from ARM entry
    clear_mon();
    do_start(25, 100);
    cyc_arm = cyc;
    wait_done(300, "t3_done_seen");
    check("t3_latency", cyc_done - cyc_arm, 100);
    check("t3_timeout", bus.timeout, 1);
    check("t3_ref", bus.ref_cnt, 0);
    check("t3_sig", bus.sig_cnt, 0);
    check("t3_no_fgate", fg_hi, 0);
    quiesce();

    // Signal dies after the 2nd edge: 25 in GATE + 50 in CLOSE
    clear_mon();
    do_start(25, 50);
    per    = 10;
    stop_n = 2;
    sig_en = 1;
    wait_done(300, "t4_done_seen");
    check("t4_timeout", bus.timeout, 1);
    check("t4_ref", bus.ref_cnt, 0);
    check("t4_close_len", cyc_done - fg_rise, 75);
    check("t4_fgate_len", fg_hi, 75);
    check("t4_fgate_at_done", fgate, 0);
    quiesce();

    // Gate expiry coincides with the 2nd edge; a second start mid-gate is ignored
    clear_mon();
    do_start(20, 0);
    per    = 10;
    sig_en = 1;
    wait_fgate(100, "t2_fgate_open");
    repeat (3) tick();
    do_start(5, 7);
    check("t2_still_gating", fgate, 1);
    wait_done(200, "t2_done_seen");
    check("t2_ref", bus.ref_cnt, 20);
    check("t2_sig", bus.sig_cnt, 2);
    check("t2_timeout", bus.timeout, 0);
    check("t2_fgate_len", fg_hi, 20);
    quiesce();

    // Abort mid-gate: no done, previous results retained
    clear_mon();
    do_start(25, 0);
    sig_en = 1;
    wait_fgate(100, "t5_fgate_open");
    repeat (5) tick();
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    check("t5_fgate_off", fgate, 0);
    check("t5_busy_off", bus.busy, 0);
    repeat (40) tick();
    check("t5_no_done", done_n, 0);
    check("t5_ref_kept", bus.ref_cnt, 20);
    check("t5_sig_kept", bus.sig_cnt, 2);
    check("t5_timeout_kept", bus.timeout, 0);
    check("t5_idle_fgate", fgate, 0);
    quiesce();

    // Async reset in CLOSE, then period 7 with gate 14
    clear_mon();
    do_start(25, 0);
    sig_en = 1;
    wait_fgate(100, "t6_fgate_open");
    repeat (26) tick();
    check("t6_in_close", fgate, 1);
    rst_n = 1'b0;
    #1;
    check("t6_rst_fgate", fgate, 0);
    check("t6_rst_busy", bus.busy, 0);
    check("t6_rst_ref", bus.ref_cnt, 0);
    check("t6_rst_sig", bus.sig_cnt, 0);
    check("t6_rst_timeout", bus.timeout, 0);
    tick();
    rst_n = 1'b1;
    quiesce();
    clear_mon();
    per = 7;
    do_start(14, 0);
    sig_en = 1;
    wait_done(200, "t6_done_seen");
    check("t6_ref", bus.ref_cnt, 14);
    check("t6_sig", bus.sig_cnt, 2);
    check("t6_timeout", bus.timeout, 0);
    check("t6_fgate_len", fg_hi, 14);
    quiesce();

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
